// File: rtl/shift_arbiter_pkg.sv
// Shared constants and state encoding for the shift arbiter slice.
package shift_arbiter_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned AMT_W  = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_arbiter_shift_logical_left.sv
// 64-bit logical left shifter, zero fill.
module shift_logical_left
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] y
);

  // Zero-filling left shift of the selected operand
  always_comb begin
    y = a << amt;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of one shared logical-left shifter with a
// single result register (EMPTY/FULL) tagged by the owning port.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data
);

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] shift_a;
  logic [AMT_W-1:0]  shift_amt;
  logic [DATA_W-1:0] shift_y;
  logic              grant;
  logic              can_accept;
  logic              drain;
  logic              accept;

  // Grant selection, drain/refill decision and operand mux
  always_comb begin
    drain      = (state == FULL) && (owner ? rsp1_ready : rsp0_ready);
    can_accept = (state == EMPTY) || drain;
    grant      = 1'b0;
    if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else if (req0_valid && req1_valid && RR_EN) begin
      grant = ~last_grant;
    end
    accept    = can_accept && (grant ? req1_valid : req0_valid);
    shift_a   = grant ? req1_a   : req0_a;
    shift_amt = grant ? req1_amt : req0_amt;
  end

  shift_logical_left u_shift (
    .a   (shift_a),
    .amt (shift_amt),
    .y   (shift_y)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a refill keeps FULL even when the old result drains
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = FULL;
    end else if (drain) begin
      state_nxt = EMPTY;
    end
  end

  // Result register, owner tag and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      result     <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      owner      <= grant;
      result     <= shift_y;
      last_grant <= grant;
    end
  end

  // Handshake outputs and owner-gated response data
  always_comb begin
    req0_ready = can_accept && !grant;
    req1_ready = can_accept && grant;
    rsp0_valid = (state == FULL) && !owner;
    rsp1_valid = (state == FULL) && owner;
    rsp0_data  = rsp0_valid ? result : '0;
    rsp1_data  = rsp1_valid ? result : '0;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed bench for shift_arbiter; instance 0 is
// round-robin, instance 1 is fixed priority, both fed the same inputs.
module tb_shift_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic              v0, v1, rr0, rr1;
  logic [63:0]       a0, a1;
  logic [5:0]        m0, m1;
  logic              r0_rr, r1_rr, rv0_rr, rv1_rr;
  logic              r0_fp, r1_fp, rv0_fp, rv1_fp;
  logic [63:0]       rd0_rr, rd1_rr, rd0_fp, rd1_fp;

  bit                m_full  [2];
  bit                m_owner [2];
  bit                m_last  [2];
  logic [63:0]       m_data  [2];
  bit                lastacc0, lastacc1;
  int unsigned       n_tests = 0;
  int unsigned       n_fail  = 0;
  logic [1:0]        order [2][3];
  logic [63:0]       bnd_a   [3];
  logic [5:0]        bnd_amt [3];
  logic [63:0]       bnd_exp [3];

  always #5 clk = ~clk;

  shift_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0_rr), .req0_a(a0), .req0_amt(m0),
    .req1_valid(v1), .req1_ready(r1_rr), .req1_a(a1), .req1_amt(m1),
    .rsp0_valid(rv0_rr), .rsp0_ready(rr0), .rsp0_data(rd0_rr),
    .rsp1_valid(rv1_rr), .rsp1_ready(rr1), .rsp1_data(rd1_rr)
  );

  shift_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0_fp), .req0_a(a0), .req0_amt(m0),
    .req1_valid(v1), .req1_ready(r1_fp), .req1_a(a1), .req1_amt(m1),
    .rsp0_valid(rv0_fp), .rsp0_ready(rr0), .rsp0_data(rd0_fp),
    .rsp1_valid(rv1_fp), .rsp1_ready(rr1), .rsp1_data(rd1_fp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Left shift as repeated doubling
  function automatic logic [63:0] ref_shift(input logic [63:0] a, input int unsigned amt);
    logic [63:0] r;
    r = a;
    for (int unsigned i = 0; i < amt; i++) r = r + r;
    return r;
  endfunction

  function automatic bit ref_grant(input int k);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    if (k == 0) return !m_last[k];
    return 1'b0;
  endfunction

  function automatic bit ref_can(input int k);
    return !m_full[k] || (m_owner[k] ? rr1 : rr0);
  endfunction

  task automatic compare_outputs();
    bit g, c;
    logic r0, r1, rv0, rv1;
    logic [63:0] rd0, rd1;
    for (int k = 0; k < 2; k++) begin
      r0  = (k == 0) ? r0_rr  : r0_fp;
      r1  = (k == 0) ? r1_rr  : r1_fp;
      rv0 = (k == 0) ? rv0_rr : rv0_fp;
      rv1 = (k == 0) ? rv1_rr : rv1_fp;
      rd0 = (k == 0) ? rd0_rr : rd0_fp;
      rd1 = (k == 0) ? rd1_rr : rd1_fp;
      if (v0 || v1) begin
        g = ref_grant(k);
        c = ref_can(k);
        check($sformatf("i%0d req0_ready", k), r0, c && !g);
        check($sformatf("i%0d req1_ready", k), r1, c && g);
      end
      check($sformatf("i%0d rsp0_valid", k), rv0, m_full[k] && !m_owner[k]);
      check($sformatf("i%0d rsp1_valid", k), rv1, m_full[k] && m_owner[k]);
      if (m_full[k]) begin
        check($sformatf("i%0d rsp0_data", k), rd0, m_owner[k] ? 64'd0 : m_data[k]);
        check($sformatf("i%0d rsp1_data", k), rd1, m_owner[k] ? m_data[k] : 64'd0);
      end
    end
  endtask

  task automatic model_edge();
    bit g, c, acc, drn;
    for (int k = 0; k < 2; k++) begin
      g   = ref_grant(k);
      c   = ref_can(k);
      acc = (v0 || v1) && c && !rst;
      drn = m_full[k] && (m_owner[k] ? rr1 : rr0);
      if (k == 0) begin
        lastacc0 = acc && !g;
        lastacc1 = acc && g;
      end
      if (rst) begin
        m_full[k] = 1'b0; m_owner[k] = 1'b0; m_data[k] = '0; m_last[k] = 1'b1;
      end else if (acc) begin
        m_full[k]  = 1'b1;
        m_owner[k] = g;
        m_data[k]  = ref_shift(g ? a1 : a0, g ? m1 : m0);
        m_last[k]  = g;
      end else if (drn) begin
        m_full[k] = 1'b0;
      end
    end
  endtask

  // Entered and left at posedge+1
  task automatic cycle();
    #3;
    compare_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
    a0 = '0; a1 = '0; m0 = '0; m1 = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 0; m_owner[k] = 0; m_data[k] = '0; m_last[k] = 1;
    end
    do_reset();

    // Single request on port 0
    v0 = 1; a0 = 64'h1; m0 = 6'd4;
    #2 check("single_ready0", r0_rr, 1'b1);
    cycle();
    v0 = 0;
    #2;
    check("single_valid0", rv0_rr, 1'b1);
    check("single_data0", rd0_rr, 64'h10);
    check("single_valid1", rv1_rr, 1'b0);
    cycle();

    // Tie held for three accepts
    do_reset();
    v0 = 1; v1 = 1; a0 = 64'h3; m0 = 6'd1; a1 = 64'h5; m1 = 6'd2;
    for (int i = 0; i < 3; i++) begin
      #2;
      order[0][i] = r1_rr ? 2'd1 : (r0_rr ? 2'd0 : 2'd3);
      order[1][i] = r1_fp ? 2'd1 : (r0_fp ? 2'd0 : 2'd3);
      cycle();
    end
    check("rr_order0", order[0][0], 2'd0);
    check("rr_order1", order[0][1], 2'd1);
    check("rr_order2", order[0][2], 2'd0);
    check("fp_order0", order[1][0], 2'd0);
    check("fp_order1", order[1][1], 2'd0);
    check("fp_order2", order[1][2], 2'd0);
    v0 = 0; v1 = 0;
    cycle();

    // Backpressure on port 1 while port 0 waits
    do_reset();
    v1 = 1; a1 = 64'hAB; m1 = 6'd4; rr1 = 0; rr0 = 1;
    cycle();
    v1 = 0; v0 = 1; a0 = 64'h7; m0 = 6'd2;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("bp_ready0", r0_rr, 1'b0);
      check("bp_data1", rd1_rr, 64'hAB0);
      cycle();
    end
    rr1 = 1;
    #2 check("bp_refill0", r0_rr, 1'b1);
    cycle();
    v0 = 0;
    #2;
    check("bp_valid0", rv0_rr, 1'b1);
    check("bp_data0", rd0_rr, 64'h1C);
    cycle();

    // Shift boundaries
    bnd_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; bnd_amt[0] = 6'd0;  bnd_exp[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    bnd_a[1] = 64'h1;                   bnd_amt[1] = 6'd63; bnd_exp[1] = 64'h8000_0000_0000_0000;
    bnd_a[2] = 64'h1234_5678_9ABC_DEF0; bnd_amt[2] = 6'd8;  bnd_exp[2] = 64'h3456_789A_BCDE_F000;
    rr0 = 1;
    for (int i = 0; i < 3; i++) begin
      v0 = 1; a0 = bnd_a[i]; m0 = bnd_amt[i];
      cycle();
      v0 = 0;
      #2 check($sformatf("bnd%0d", i), rd0_rr, bnd_exp[i]);
      cycle();
    end

    // Reset while a result is held
    do_reset();
    v0 = 1; a0 = 64'h5; m0 = 6'd1; rr0 = 0;
    cycle();
    v0 = 0;
    #2 check("mid_valid_before", rv0_rr, 1'b1);
    rst = 1;
    cycle();
    rst = 0;
    #2 check("mid_valid_after", rv0_rr, 1'b0);
    v0 = 1; v1 = 1;
    #2 check("mid_tie_port0", r0_rr, 1'b1);
    cycle();
    v0 = 0; v1 = 0; rr0 = 1;
    cycle();
    cycle();

    // Randomized traffic with held requests
    lastacc0 = 0; lastacc1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!v0 || lastacc0) begin
        v0 = 1'($urandom_range(0, 1)); a0 = {$urandom, $urandom}; m0 = 6'($urandom_range(0, 63));
      end
      if (!v1 || lastacc1) begin
        v1 = 1'($urandom_range(0, 1)); a1 = {$urandom, $urandom}; m1 = 6'($urandom_range(0, 63));
      end
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
